// File: rtl/spike_pkg.sv
// Shared definitions for the spike_enc rate-coded event generator:
// FSM state type, default widths and the LFSR feedback constants.
package spike_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } spike_state_e;

  localparam int unsigned SPIKE_WIDTH_DEF  = 8;
  localparam int unsigned SPIKE_CWIDTH_DEF = 8;
  localparam int unsigned SPIKE_GAP_DEF    = 2;
  localparam logic [7:0]  SPIKE_SEED_DEF   = 8'hA5;

  // Right-shift Galois feedback mask for x^8 + x^6 + x^5 + x^4 + 1 (maximal length).
  localparam logic [7:0]  SPIKE_LFSR_TAPS_W8 = 8'hB8;

  // Feedback mask lookup for the supported LFSR widths; 8 bits is the normal case.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      4:       taps = 32'h0000_000C;
      8:       taps = {24'h0, SPIKE_LFSR_TAPS_W8};
      16:      taps = 32'h0000_B400;
      default: taps = {24'h0, SPIKE_LFSR_TAPS_W8};
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/spike_lfsr.sv
// Free-running Galois LFSR used to randomise the initial accumulator phase
// of spike_enc. Advances every cycle; reset loads p_seed (must be non-zero).
module spike_lfsr
  import spike_pkg::*;
#(
  parameter int unsigned          p_width = SPIKE_WIDTH_DEF,
  parameter logic [p_width-1:0]   p_seed  = p_width'(SPIKE_SEED_DEF)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [p_width-1:0] o_state
);

  localparam logic [31:0] TAPS = lfsr_taps(p_width);

  logic [p_width-1:0] state_q;
  logic [p_width-1:0] state_d;

  // Shift right and fold the feedback mask in whenever a one falls out.
  always_comb begin
    state_d = state_q >> 1;
    if (state_q[0]) begin
      state_d = state_d ^ TAPS[p_width-1:0];
    end
  end

  // State register with synchronous reset to the seed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= p_seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: rtl/spike_enc.sv
// Rate-coded spike event generator (phase accumulator). Each RUN cycle adds
// the latched rate to the accumulator; every carry-out emits one o_event
// pulse, followed by p_gap refractory cycles. A run ends after the programmed
// event count (0 = free-run) or on i_stop.
// Optional build macro: SPIKE_ENC_DITHER_EN seeds the accumulator from an LFSR
// at start so first-event phase differs across instances.
module spike_enc
  import spike_pkg::*;
#(
  parameter int unsigned        p_width  = SPIKE_WIDTH_DEF,
  parameter int unsigned        p_cwidth = SPIKE_CWIDTH_DEF,
  parameter int unsigned        p_gap    = SPIKE_GAP_DEF,
  parameter logic [p_width-1:0] p_seed   = p_width'(SPIKE_SEED_DEF)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [p_width-1:0]  i_rate,
  input  logic [p_cwidth-1:0] i_count,
  input  logic                i_stop,
  output logic                o_event,
  output logic                o_busy,
  output logic                o_done,
  output logic [p_cwidth-1:0] o_sent
);

  localparam int unsigned GW = (p_gap > 0) ? $clog2(p_gap + 1) : 1;

  spike_state_e        state_q, state_d;
  logic [p_width-1:0]  r_q, r_d;
  logic [p_cwidth-1:0] c_q, c_d;
  logic [p_width-1:0]  acc_q, acc_d;
  logic [p_cwidth-1:0] sent_q, sent_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                event_q, event_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [p_width-1:0]  seed_val;
  logic [p_width:0]    sum;
  logic                carry;
  logic [p_cwidth-1:0] sent_inc;
  logic                final_evt;

`ifdef SPIKE_ENC_DITHER_EN
  logic [p_width-1:0] lfsr_state;

  spike_lfsr #(
    .p_width (p_width),
    .p_seed  (p_seed)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .o_state (lfsr_state)
  );

  assign seed_val = lfsr_state;
`else
  assign seed_val = '0;
`endif

  // Accumulator add with carry, and detection of the run's last counted event.
  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, r_q};
    carry     = sum[p_width];
    sent_inc  = sent_q + p_cwidth'(1);
    final_evt = carry && (c_q != '0) && (sent_inc == c_q);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop takes priority over a same-cycle carry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (carry) begin
          if (final_evt) begin
            state_d = ST_IDLE;
          end else if (p_gap > 0) begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (gap_q == GW'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    r_d     = r_q;
    c_d     = c_q;
    acc_d   = acc_q;
    sent_d  = sent_q;
    gap_d   = gap_q;
    event_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          r_d    = i_rate;
          c_d    = i_count;
          acc_d  = seed_val;
          sent_d = '0;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          done_d = 1'b1;
        end else begin
          acc_d = sum[p_width-1:0];
          if (carry) begin
            event_d = 1'b1;
            // Free-run counts saturate instead of wrapping.
            if (sent_q != '1) begin
              sent_d = sent_inc;
            end
            if (final_evt) begin
              done_d = 1'b1;
            end else begin
              gap_d = GW'(p_gap);
            end
          end
        end
      end
      ST_GAP: begin
        if (i_stop) begin
          done_d = 1'b1;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      sent_q  <= '0;
      gap_q   <= '0;
      event_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      r_q     <= r_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      sent_q  <= sent_d;
      gap_q   <= gap_d;
      event_q <= event_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_event = event_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_sent  = sent_q;

endmodule

// File: doc/spike_enc.md
# spike_enc

Rate-coded spike event generator: the transmitter that produces the one-cycle `i_event` pulses consumed by a `wlif` neuron input. It uses a phase-accumulator rate code: a programmed rate value is added every active cycle, and each carry-out emits one event. A programmable event count, a stop request and a fixed refractory gap bound the output. It sits between the stimulus/control logic and the neuron array, one instance per driven synapse.

## Interface
- `p_width`, 8: rate and accumulator width; event probability per RUN cycle = `i_rate`/2^`p_width`.
- `p_cwidth`, 8: width of the event count and `o_sent`.
- `p_gap`, 2: refractory cycles after each event (0 allowed).
- `p_seed`, 8'hA5: non-zero LFSR seed (dither build only).

Ports:
- `i_clk`  in  1  clock, all logic on rising edge.
- `i_rst`  in  1  reset, **synchronous, active-high**.
- `i_start`  in  1  one-cycle request; latches `i_rate` and `i_count` when idle.
- `i_rate`  in  `p_width`  accumulator increment.
- `i_count`  in  `p_cwidth`  events to emit; 0 = free-run until `i_stop`.
- `i_stop`  in  1  abort the current run.
- `o_event`  out  1  one-cycle spike pulse (drives `wlif.i_event`).
- `o_busy`  out  1  high in RUN/GAP.
- `o_done`  out  1  one-cycle completion/abort pulse.
- `o_sent`  out  `p_cwidth`  events emitted in the current run; holds after done.

## Operation
- States: IDLE, RUN, GAP.
- IDLE:
  - `i_start` sampled → latch rate `r` and count `c`; `acc`<=seed (0 without dither); `o_sent`<=0; go to RUN.
  - `i_stop` in IDLE: ignored.
- RUN, every cycle:
  - `{carry, acc}` <= `acc` + `r` (`p_width`+1-bit add; the carry bit is discarded from `acc`).
  - `o_event` <= `carry`.
  - On carry: `o_sent`+1. If `c`≠0 and `o_sent`+1 == `c` → IDLE with `o_done`<=1 in the same cycle as the final `o_event`. Otherwise, if `p_gap`>0 → GAP with gap counter = `p_gap`.
- GAP:
  - `acc` frozen; `o_event`=0.
  - Counter decrements each cycle; returns to RUN after exactly `p_gap` cycles.
- `i_stop` in RUN/GAP:
  - → IDLE; `o_done`<=1 the next cycle; `o_event`<=0.
  - Stop wins over a simultaneous carry: no event, `o_sent` unchanged.
- `i_start` while busy: ignored. Latched `r`/`c` do not change mid-run.
- `r`=0: no events; a run ends only by `i_stop`.
- `r`=2^`p_width`−1 with `p_gap`=0: 255 events per 256 cycles.
- `o_sent` saturates at all-ones in free-run mode (no wrap).

## Timing
- Reset values: state IDLE; `o_event`=0, `o_busy`=0, `o_done`=0, `o_sent`=0; `acc`=0; LFSR=`p_seed`.
- All outputs are registered.
- `o_busy` rises on the edge that samples `i_start`.
- `o_busy` falls on the edge that sets `o_done`.
- First event: earliest on the 1st RUN edge (r ≥ 2^`p_width` − seed). With seed 0 and r=128: 2nd RUN edge.
- Event period in steady state: ceil-ish 2^`p_width`/`r` RUN cycles plus `p_gap`.
- `i_rst` mid-run: next edge forces reset values. No `o_done` is produced.

## Configuration
- `SPIKE_ENC_DITHER_EN` defined:
  - Instantiates a `p_width`-bit maximal LFSR advancing every cycle.
  - On `i_start`, `acc` is seeded with the current LFSR value, so first-event phase is randomized across instances.
  - Long-run rate is unchanged.
- Undefined: no LFSR; seed is 0 and behaviour is fully deterministic.

## Structure
- Shared package `spike_pkg` holds:
  - state enum (IDLE/RUN/GAP);
  - default widths;
  - the LFSR tap constant for width 8.
- One sub-module: `spike_lfsr` (Galois LFSR, parameters `p_width` and `p_seed`). It is present only under `SPIKE_ENC_DITHER_EN`.

## Test plan
- Reset: assert `i_rst` 3 cycles → all outputs 0. `i_start` held during reset is ignored.
- r=128, c=4, `p_gap`=2, no dither, start at edge 0:
  - `o_event` at edges 2, 6, 10, 14;
  - `o_done` coincides with edge 14;
  - `o_sent`=4;
  - `o_busy` low after edge 14.
- r=255, c=0, `p_gap`=0, stop after 300 cycles:
  - 298–299 events counted;
  - `o_done` 1 cycle after stop;
  - no event in the stop cycle.
- r=0, c=3: no events for 1000 cycles; `o_busy` stays high; `i_stop` → `o_done`, `o_sent`=0.
- Start while busy with r=200: ignored; latched r=128 cadence unchanged. `i_rst` at cycle 7 of the run → IDLE next edge, no `o_done`.
- Dither build, two instances with seeds 8'hA5 and 8'h3C, r=64, c=16:
  - differing first-event cycles;
  - both emit 16 events within 16×4+16×`p_gap` ±1 cycles.
